// File: rtl/io_dev_pkg.sv
// Shared types and constants for the io_dma_device peripheral.
package io_dev_pkg;

    // CPU-side bus target handshake
    typedef enum logic {
        SIdle,
        SAck
    } slave_state_t;

    // DMA request/stream sequencer
    typedef enum logic [1:0] {
        DIdle,
        DReq,
        DXfer,
        DDone
    } dma_state_t;

    // STATUS register bit positions
    localparam int unsigned BUSY_BIT = 0;
    localparam int unsigned IRQ_BIT  = 1;

endpackage

// File: rtl/io_dma_seq.sv
// DMA sequencer: request/ack handshake, stream pointer with wrap, beat counter
// and tready_i rising-edge detection. One accepted tready_i rise = one beat.
module io_dma_seq
    import io_dev_pkg::*;
#(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned DMA_START = 3,
    parameter int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dev_event_i,
    input  logic             start_i,
    input  logic             dack_i,
    input  logic             tready_i,
    output logic [PTR_W-1:0] ptr_o,
    output logic             beat_stb_o,
    output logic             xfer_o,
    output logic             dreq_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

    dma_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              trdy_q;
    logic              ev_q;
    logic              trdy_rise;
    logic              ev_rise;

    assign trdy_rise = tready_i & ~trdy_q;
    assign ev_rise   = dev_event_i & ~ev_q;

    // State, counters and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIdle;
            ptr_q   <= PTR_W'(DMA_START);
            beat_q  <= '0;
            trdy_q  <= 1'b0;
            ev_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            trdy_q  <= tready_i;
            ev_q    <= dev_event_i;
        end
    end

    // Next-state and beat accounting; events outside DIdle are dropped, not queued
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        beat_stb_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            DIdle: begin
                if (ev_rise || start_i) begin
                    ptr_d   = PTR_W'(DMA_START);
                    beat_d  = '0;
                    state_d = DReq;
                end
            end
            DReq: begin
                if (dack_i) begin
                    state_d = DXfer;
                end
            end
            DXfer: begin
                if (!dack_i) begin
                    // Grant withdrawn: re-request, keep position to resume
                    state_d = DReq;
                end else if (trdy_rise) begin
                    beat_stb_o = 1'b1;
                    ptr_d      = ptr_q + PTR_W'(1);
                    beat_d     = beat_q + BEAT_W'(1);
                    if (beat_d == BEAT_W'(BURST_LEN)) begin
                        state_d = DDone;
                    end
                end
            end
            DDone: begin
                if (!dack_i) begin
                    state_d = DIdle;
                    done_o  = 1'b1;
                end
            end
            default: state_d = DIdle;
        endcase
    end

    assign ptr_o  = ptr_q;
    assign xfer_o = (state_q == DXfer);
    assign dreq_o = (state_q == DReq) || (state_q == DXfer);
    assign busy_o = (state_q != DIdle);

endmodule

// File: rtl/io_dma_device.sv
// Memory-mapped IO peripheral with a DEPTH-word buffer, a STATUS register and
// DMA source/sink streaming. Optional burst-complete interrupt: IO_DMA_IRQ_EN.
module io_dma_device
    import io_dev_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned BASE_ADDR = 1001,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned DMA_START = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    input  logic              ior,
    input  logic              iow,
    input  logic              iready,
    output logic              tready_o,
    input  logic              tready_i,
    input  logic              dev_event,
    output logic              dreq,
    input  logic              dack,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BASE_ADDR + DEPTH);

    slave_state_t      slave_q, slave_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] status_word;
    logic [ADDR_W-1:0] offs;
    logic [PTR_W-1:0]  mem_idx;
    logic              cs, is_status, access;
    logic              cpu_wr, cpu_rd, status_start;
    logic              irq_pend;
    logic [PTR_W-1:0]  dma_ptr;
    logic              dma_beat, dma_xfer, dma_busy, dma_done;
    logic              dma_src, dma_wr;

    assign cs        = (addr >= FIRST) && (addr <= LAST);
    assign offs      = addr - FIRST;
    assign is_status = (offs == ADDR_W'(DEPTH));
    assign mem_idx   = offs[PTR_W-1:0];
    // A granted DMA owns the bus, so dack blocks CPU acks
    assign access    = iready & cs & ~dack & (ior ^ iow);

    io_dma_seq #(
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .DMA_START (DMA_START),
        .PTR_W     (PTR_W)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .dev_event_i (dev_event),
        .start_i     (status_start),
        .dack_i      (dack),
        .tready_i    (tready_i),
        .ptr_o       (dma_ptr),
        .beat_stb_o  (dma_beat),
        .xfer_o      (dma_xfer),
        .dreq_o      (dreq),
        .busy_o      (dma_busy),
        .done_o      (dma_done)
    );

    assign dma_src = dma_xfer & dack & ior;
    assign dma_wr  = dma_beat & iow;

    // STATUS register view
    always_comb begin
        status_word           = '0;
        status_word[BUSY_BIT] = dma_busy;
        status_word[IRQ_BIT]  = irq_pend;
    end

    // Slave handshake: accept in SIdle, hold tready_o until iready drops
    always_comb begin
        slave_d = slave_q;
        rdata_d = rdata_q;
        cpu_wr  = 1'b0;
        cpu_rd  = 1'b0;
        case (slave_q)
            SIdle: begin
                if (access) begin
                    slave_d = SAck;
                    cpu_wr  = iow;
                    cpu_rd  = ior;
                end
            end
            SAck: begin
                if (!iready) begin
                    slave_d = SIdle;
                end
            end
            default: slave_d = SIdle;
        endcase
        if (cpu_rd) begin
            rdata_d = is_status ? status_word : mem_q[mem_idx];
        end
    end

    assign status_start = cpu_wr & is_status & wdata[BUSY_BIT];

    // Slave state and captured read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slave_q <= SIdle;
            rdata_q <= '0;
        end else begin
            slave_q <= slave_d;
            rdata_q <= rdata_d;
        end
    end

    // Buffer: reset pattern 2*i, DMA sink write has priority over CPU write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(2 * i);
            end
        end else if (dma_wr) begin
            mem_q[dma_ptr] <= wdata;
        end else if (cpu_wr && !is_status) begin
            mem_q[mem_idx] <= wdata;
        end
    end

`ifdef IO_DMA_IRQ_EN
    logic irq_pend_q, irq_pend_d;
    logic irq_clr;

    assign irq_clr = cpu_wr & is_status & wdata[IRQ_BIT];

    // Pending flag: set on burst completion (wins over a same-cycle clear)
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (irq_clr) begin
            irq_pend_d = 1'b0;
        end
        if (dma_done) begin
            irq_pend_d = 1'b1;
        end
    end

    // Interrupt pending register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pend_q <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq_pend = irq_pend_q;
`else
    logic unused_dma_done;

    assign unused_dma_done = dma_done;
    assign irq_pend        = 1'b0;
`endif

    assign irq      = irq_pend;
    assign tready_o = (slave_q == SAck);
    assign rdata_oe = dma_src | ((slave_q == SAck) & ior);
    assign rdata    = dma_src ? mem_q[dma_ptr] : (rdata_oe ? rdata_q : '0);

endmodule
